// File: rtl/pulse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_pkg
//  Description : Shared types and constants for the pulse scheduler slice:
//                the 32-bit AXI4-Stream bundle and the DAC sink FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package pulse_pkg;

    // AXI4-Stream bundle produced by pulse_engine on m_axis.
    typedef struct packed {
        logic [31:0] tdata;
        logic        tvalid;
        logic        tlast;
    } axis32_t;

    // Prefixed so the names do not collide with the PREFILL threshold parameter.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PREFILL = 2'd1,
        S_PLAY    = 2'd2
    } dac_sink_state_e;

    localparam int DAC_SINK_DEPTH_DEFAULT = 16;

endpackage : pulse_pkg
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sample_fifo
//  Description : Synchronous FIFO with a registered read port. Pointers carry
//                one extra wrap bit so full/empty come from an MSB compare.
//  Ports       : clk, rst_n (sync, active-low), flush (sync clear),
//                wr_en/wr_data (write, ignored when full),
//                rd_en (pop, ignored when empty), rd_data (updated on pop),
//                full, empty, level (entries held).
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_wr;
    logic         w_rd;

    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign empty = (r_wptr == r_rptr);
    assign level = r_wptr - r_rptr;

    // A full FIFO refuses the write even if a pop frees a slot this cycle.
    assign w_wr = wr_en && !full  && !flush;
    assign w_rd = rd_en && !empty && !flush;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            rd_data <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr  <= r_rptr + 1'b1;
                rd_data <= r_mem[r_rptr[AW-1:0]];
            end
        end
    end

endmodule : sample_fifo
`default_nettype wire

// File: rtl/axis_dac_sink.sv
`default_nettype none
// ============================================================================
//  Module      : axis_dac_sink
//  Description : AXI4-Stream sample sink feeding the DAC. Buffers a pulse,
//                starts playback at a prefill level (or once a tlast is held),
//                then plays one sample every dac_div+1 cycles, flagging
//                underflow when the buffer runs dry mid-pulse.
//  Ports       : s_axis_* (sample input, tready = !full), dac_div (rate),
//                abort (flush to IDLE), clear_underflow, dac_data/dac_valid
//                (output strobe), busy, underflow, underflow_cnt, sample_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_dac_sink
    import pulse_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = DAC_SINK_DEPTH_DEFAULT,
    parameter int PREFILL = 4,
    parameter int DIV_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    input  logic [DIV_W-1:0]  dac_div,
    input  logic              abort,
    input  logic              clear_underflow,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_valid,
    output logic              busy,
    output logic              underflow,
    output logic [15:0]       underflow_cnt,
    output logic [31:0]       sample_cnt
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] c_prefill_lvl = LW'(PREFILL);

    dac_sink_state_e r_state;
    dac_sink_state_e w_state_nxt;

    logic [DIV_W-1:0] r_div_q;
    logic [DIV_W-1:0] r_div_cnt;
    logic [LW-1:0]    r_last_pend;
    logic             r_dac_valid;
    logic             r_dac_sel;
    logic             r_underflow;
    logic [15:0]      r_ucnt;
    logic [31:0]      r_scnt;

    logic [DATA_W:0]  w_rd_data;
    logic [LW-1:0]    w_level;
    logic             w_full;
    logic             w_empty;
    logic             w_wr;
    logic             w_strobe;
    logic             w_pop;
    logic             w_underflow;
    logic             w_popped_last;
    logic             w_enter_prefill;
    logic             w_enter_play;
    logic             w_last_inc;

    sample_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (abort),
        .wr_en   (w_wr),
        .wr_data ({s_axis_tlast, s_axis_tdata}),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty),
        .level   (w_level)
    );

    assign s_axis_tready = !w_full;
    assign w_wr          = s_axis_tvalid && !w_full && !abort;
    assign w_last_inc    = w_wr && s_axis_tlast;

    // The FIFO read port is registered, so the tlast of a popped entry is seen
    // in the cycle after the pop, while its sample is on dac_data. That cycle
    // ends the pulse and must not start another pop.
    assign w_popped_last = r_dac_valid && r_dac_sel && w_rd_data[DATA_W];

    assign w_strobe    = (r_state == S_PLAY) && (r_div_cnt == '0) && !w_popped_last;
    assign w_pop       = w_strobe && !w_empty && !abort;
    assign w_underflow = w_strobe &&  w_empty && !abort;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (!w_empty) w_state_nxt = S_PREFILL;
            S_PREFILL: if ((w_level >= c_prefill_lvl) || (r_last_pend != '0)) w_state_nxt = S_PLAY;
            S_PLAY:    if (w_popped_last) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    assign w_enter_prefill = (r_state != S_PREFILL) && (w_state_nxt == S_PREFILL);
    assign w_enter_play    = (r_state != S_PLAY)    && (w_state_nxt == S_PLAY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_div_q     <= '0;
            r_div_cnt   <= '0;
            r_last_pend <= '0;
            r_dac_valid <= 1'b0;
            r_dac_sel   <= 1'b0;
            r_underflow <= 1'b0;
            r_ucnt      <= '0;
            r_scnt      <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (abort) begin
                r_div_cnt   <= '0;
                r_last_pend <= '0;
                r_dac_valid <= 1'b0;
                r_dac_sel   <= 1'b0;
            end else begin
                case ({w_last_inc, w_popped_last})
                    2'b10:   r_last_pend <= r_last_pend + 1'b1;
                    2'b01:   r_last_pend <= r_last_pend - 1'b1;
                    default: r_last_pend <= r_last_pend;
                endcase

                if (w_enter_play) begin
                    r_div_q   <= dac_div;
                    r_div_cnt <= '0;
                end else if (r_state == S_PLAY) begin
                    if (w_strobe) begin
                        r_div_cnt <= r_div_q;
                    end else if (r_div_cnt != '0) begin
                        r_div_cnt <= r_div_cnt - 1'b1;
                    end
                end

                r_dac_valid <= w_pop || w_underflow;

                // dac_data shows the FIFO read register after a pop and zero
                // after an underflow; it holds between strobes.
                if (w_pop) begin
                    r_dac_sel <= 1'b1;
                end else if (w_underflow) begin
                    r_dac_sel <= 1'b0;
                end

                if (w_enter_prefill) begin
                    r_scnt <= '0;
                end else if (w_pop) begin
                    r_scnt <= r_scnt + 1'b1;
                end
            end

            // Set has priority over clear.
            if (w_underflow) begin
                r_underflow <= 1'b1;
                if (r_ucnt != 16'hFFFF) begin
                    r_ucnt <= r_ucnt + 1'b1;
                end
            end else if (clear_underflow) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign dac_data      = r_dac_sel ? w_rd_data[DATA_W-1:0] : '0;
    assign dac_valid     = r_dac_valid;
    assign busy          = (r_state != S_IDLE);
    assign underflow     = r_underflow;
    assign underflow_cnt = r_ucnt;
    assign sample_cnt    = r_scnt;

endmodule : axis_dac_sink
`default_nettype wire

// File: tb/tb_axis_dac_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_dac_sink
//  Description : Self-checking bench for axis_dac_sink. Pulses are driven
//                sample by sample; every dac_valid strobe is logged with its
//                cycle and compared against the sent samples, the programmed
//                rate and the prefill start latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_dac_sink;
    import pulse_pkg::*;

    localparam int DEPTH   = 16;
    localparam int PREFILL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    axis32_t     s_axis;
    logic        tready;
    logic [7:0]  dac_div;
    logic        abort;
    logic        clr;
    logic [31:0] dac_data;
    logic        dac_valid;
    logic        busy;
    logic        underflow;
    logic [15:0] ucnt;
    logic [31:0] scnt;

    always #5 clk = ~clk;

    axis_dac_sink #(
        .DATA_W  (32),
        .DEPTH   (DEPTH),
        .PREFILL (PREFILL),
        .DIV_W   (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axis_tdata    (s_axis.tdata),
        .s_axis_tvalid   (s_axis.tvalid),
        .s_axis_tlast    (s_axis.tlast),
        .s_axis_tready   (tready),
        .dac_div         (dac_div),
        .abort           (abort),
        .clear_underflow (clr),
        .dac_data        (dac_data),
        .dac_valid       (dac_valid),
        .busy            (busy),
        .underflow       (underflow),
        .underflow_cnt   (ucnt),
        .sample_cnt      (scnt)
    );

    typedef struct {
        int          c;
        logic [31:0] d;
        logic        uf;
        logic [15:0] uc;
    } ev_t;

    int          cyc = 0;
    ev_t         evq[$];
    logic [31:0] exp_q[$];
    int          wr_cyc[$];
    int          accepted;
    int          stall_at;
    int          checks = 0;
    int          errors = 0;
    int          exp_ucnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && dac_valid === 1'b1) begin
            evq.push_back('{cyc, dac_data, underflow, ucnt});
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_sb();
        evq.delete();
        exp_q.delete();
        wr_cyc.delete();
        accepted = 0;
        stall_at = -1;
    endtask

    task automatic drive_pulse(input int n, input bit with_last, input bit seq);
        int          guard;
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            d = seq ? 32'(i + 1) : $urandom;
            s_axis.tdata  = d;
            s_axis.tvalid = 1'b1;
            s_axis.tlast  = with_last && (i == n - 1);
            guard = 0;
            while (!tready && guard < 4000) begin
                if (stall_at < 0) stall_at = accepted;
                step();
                guard++;
            end
            if (guard >= 4000) begin
                checks++; errors++;
                $display("FAIL drive_timeout sample %0d never accepted", i);
                break;
            end
            wr_cyc.push_back(cyc + 1);
            exp_q.push_back(d);
            accepted++;
            step();
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        s_axis.tdata  = '0;
    endtask

    task automatic wait_n(input int n, input int budget);
        int g = 0;
        while (evq.size() < n && g < budget) begin
            step();
            g++;
        end
        if (evq.size() < n) begin
            checks++; errors++;
            $display("FAIL wait_outputs got %0d strobes required %0d", evq.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int g = 0;
        while (busy && g < budget) begin
            step();
            g++;
        end
    endtask

    // Cycle of the first dac_valid derived from the start rules: playback
    // starts on the write reaching PREFILL entries or carrying tlast; a lone
    // one-sample pulse also pays the IDLE->PREFILL cycle.
    function automatic int first_out_cycle(input int len);
        int sat = (len < PREFILL) ? len : PREFILL;
        return wr_cyc[sat - 1] + ((sat == 1) ? 3 : 2);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (tready !== 1'b1)   begin errors++; $display("FAIL reset_tready got %b need 1", tready); end
        checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b need 0", dac_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b need 0", busy); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_uf got %b need 0", underflow); end
        checks++; if (ucnt !== 16'd0)     begin errors++; $display("FAIL reset_ucnt got %0d need 0", ucnt); end
        checks++; if (scnt !== 32'd0)     begin errors++; $display("FAIL reset_scnt got %0d need 0", scnt); end
        checks++; if (dac_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h need 0", dac_data); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_burst(input int div);
        clear_sb();
        dac_div = 8'(div);
        drive_pulse(8, 1'b1, 1'b1);
        wait_n(8, 40 + 16 * (div + 1));
        wait_idle(50);
        repeat (4) step();
        checks++; if (evq.size() != 8) begin errors++; $display("FAIL burst_count div=%0d got %0d need 8", div, evq.size()); end
        for (int i = 0; i < evq.size() && i < 8; i++) begin
            checks++;
            if (evq[i].d !== exp_q[i]) begin errors++; $display("FAIL burst_data div=%0d idx %0d got %h need %h", div, i, evq[i].d, exp_q[i]); end
            if (i > 0) begin
                checks++;
                if (evq[i].c - evq[i-1].c != div + 1) begin errors++; $display("FAIL burst_spacing div=%0d idx %0d got %0d need %0d", div, i, evq[i].c - evq[i-1].c, div + 1); end
            end
        end
        if (evq.size() > 0) begin
            checks++;
            if (evq[0].c != first_out_cycle(8)) begin errors++; $display("FAIL burst_latency got %0d need %0d", evq[0].c, first_out_cycle(8)); end
        end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL burst_busy got %b need 0", busy); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL burst_uf got %b need 0", underflow); end
        checks++; if (scnt !== 32'd8)     begin errors++; $display("FAIL burst_scnt got %0d need 8", scnt); end
    endtask

    task automatic test_random_pulses();
        int len;
        int div;
        for (int it = 0; it < 5; it++) begin
            clear_sb();
            len = $urandom_range(1, 12);
            div = $urandom_range(0, 3);
            dac_div = 8'(div);
            drive_pulse(len, 1'b1, 1'b0);
            wait_n(len, 60 + 2 * len * (div + 1));
            wait_idle(50);
            repeat (4) step();
            checks++; if (evq.size() != len) begin errors++; $display("FAIL rand_count it %0d got %0d need %0d", it, evq.size(), len); end
            for (int i = 0; i < evq.size() && i < len; i++) begin
                checks++;
                if (evq[i].d !== exp_q[i]) begin errors++; $display("FAIL rand_data it %0d idx %0d got %h need %h", it, i, evq[i].d, exp_q[i]); end
                if (i > 0) begin
                    checks++;
                    if (evq[i].c - evq[i-1].c != div + 1) begin errors++; $display("FAIL rand_spacing it %0d idx %0d got %0d need %0d", it, i, evq[i].c - evq[i-1].c, div + 1); end
                end
            end
            if (evq.size() > 0) begin
                checks++;
                if (evq[0].c != first_out_cycle(len)) begin errors++; $display("FAIL rand_latency it %0d len %0d got %0d need %0d", it, len, evq[0].c, first_out_cycle(len)); end
            end
            checks++; if (scnt !== 32'(len)) begin errors++; $display("FAIL rand_scnt it %0d got %0d need %0d", it, scnt, len); end
            checks++; if (ucnt !== 16'(exp_ucnt)) begin errors++; $display("FAIL rand_ucnt it %0d got %0d need %0d", it, ucnt, exp_ucnt); end
        end
    endtask

    task automatic test_underflow();
        int base = exp_ucnt;
        clear_sb();
        dac_div = 8'd0;
        drive_pulse(5, 1'b0, 1'b1);
        wait_n(7, 60);
        // Abort right after the second underflow strobe so the count is exact.
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int i = 0; i < evq.size() && i < 5; i++) begin
            checks++;
            if (evq[i].d !== exp_q[i]) begin errors++; $display("FAIL uf_data idx %0d got %h need %h", i, evq[i].d, exp_q[i]); end
        end
        if (evq.size() >= 7) begin
            checks++; if (evq[5].d !== 32'd0)          begin errors++; $display("FAIL uf_zero got %h need 0", evq[5].d); end
            checks++; if (evq[5].uf !== 1'b1)          begin errors++; $display("FAIL uf_flag got %b need 1", evq[5].uf); end
            checks++; if (evq[5].uc !== 16'(base + 1)) begin errors++; $display("FAIL uf_cnt1 got %0d need %0d", evq[5].uc, base + 1); end
            checks++; if (evq[6].uc !== 16'(base + 2)) begin errors++; $display("FAIL uf_cnt2 got %0d need %0d", evq[6].uc, base + 2); end
        end
        exp_ucnt = base + 2;
        checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL uf_abort_busy got %b need 0", busy); end
        checks++; if (dac_valid !== 1'b0)      begin errors++; $display("FAIL uf_abort_valid got %b need 0", dac_valid); end
        checks++; if (underflow !== 1'b1)      begin errors++; $display("FAIL uf_kept got %b need 1", underflow); end
        checks++; if (ucnt !== 16'(exp_ucnt))  begin errors++; $display("FAIL uf_abort_cnt got %0d need %0d", ucnt, exp_ucnt); end
        checks++; if (scnt !== 32'd5)          begin errors++; $display("FAIL uf_scnt got %0d need 5", scnt); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (underflow !== 1'b0)      begin errors++; $display("FAIL uf_clear got %b need 0", underflow); end
        checks++; if (ucnt !== 16'(exp_ucnt))  begin errors++; $display("FAIL uf_clear_cnt got %0d need %0d", ucnt, exp_ucnt); end
    endtask

    task automatic test_backpressure();
        clear_sb();
        dac_div = 8'd255;
        drive_pulse(20, 1'b1, 1'b0);
        // One sample has already been popped when the 16-entry buffer fills.
        checks++; if (stall_at != DEPTH + 1) begin errors++; $display("FAIL bp_stall_point got %0d need %0d", stall_at, DEPTH + 1); end
        wait_n(20, 20 * 256 + 200);
        wait_idle(300);
        repeat (4) step();
        checks++; if (evq.size() != 20) begin errors++; $display("FAIL bp_count got %0d need 20", evq.size()); end
        for (int i = 0; i < evq.size() && i < 20; i++) begin
            checks++;
            if (evq[i].d !== exp_q[i]) begin errors++; $display("FAIL bp_data idx %0d got %h need %h", i, evq[i].d, exp_q[i]); end
            if (i > 0) begin
                checks++;
                if (evq[i].c - evq[i-1].c != 256) begin errors++; $display("FAIL bp_spacing idx %0d got %0d need 256", i, evq[i].c - evq[i-1].c); end
            end
        end
        checks++; if (ucnt !== 16'(exp_ucnt)) begin errors++; $display("FAIL bp_ucnt got %0d need %0d", ucnt, exp_ucnt); end
    endtask

    task automatic test_short_and_abort();
        clear_sb();
        dac_div = 8'd0;
        drive_pulse(2, 1'b1, 1'b0);
        wait_n(2, 40);
        wait_idle(20);
        repeat (3) step();
        checks++; if (evq.size() != 2) begin errors++; $display("FAIL short_count got %0d need 2", evq.size()); end
        for (int i = 0; i < evq.size() && i < 2; i++) begin
            checks++;
            if (evq[i].d !== exp_q[i]) begin errors++; $display("FAIL short_data idx %0d got %h need %h", i, evq[i].d, exp_q[i]); end
        end
        if (evq.size() > 0) begin
            checks++;
            if (evq[0].c != first_out_cycle(2)) begin errors++; $display("FAIL short_latency got %0d need %0d", evq[0].c, first_out_cycle(2)); end
        end
        checks++; if (underflow !== 1'b0)     begin errors++; $display("FAIL short_uf got %b need 0", underflow); end
        checks++; if (ucnt !== 16'(exp_ucnt)) begin errors++; $display("FAIL short_ucnt got %0d need %0d", ucnt, exp_ucnt); end

        clear_sb();
        dac_div = 8'd7;
        drive_pulse(10, 1'b1, 1'b0);
        wait_n(3, 100);
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy got %b need 0", busy); end
        checks++; if (tready !== 1'b1)    begin errors++; $display("FAIL abort_tready got %b need 1", tready); end
        checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b need 0", dac_valid); end
        checks++; if (dac_data !== 32'd0) begin errors++; $display("FAIL abort_data got %h need 0", dac_data); end
        checks++; if (scnt !== 32'd3)     begin errors++; $display("FAIL abort_scnt got %0d need 3", scnt); end
        repeat (40) step();
        checks++; if (evq.size() != 3) begin errors++; $display("FAIL abort_quiet got %0d strobes need 3", evq.size()); end

        // A fresh pulse after abort must wait for the full prefill again.
        clear_sb();
        dac_div = 8'd1;
        drive_pulse(6, 1'b1, 1'b0);
        wait_n(6, 80);
        wait_idle(20);
        for (int i = 0; i < evq.size() && i < 6; i++) begin
            checks++;
            if (evq[i].d !== exp_q[i]) begin errors++; $display("FAIL recover_data idx %0d got %h need %h", i, evq[i].d, exp_q[i]); end
        end
        if (evq.size() > 0) begin
            checks++;
            if (evq[0].c != first_out_cycle(6)) begin errors++; $display("FAIL recover_latency got %0d need %0d", evq[0].c, first_out_cycle(6)); end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_axis  = '0;
        dac_div = 8'd0;
        abort   = 1'b0;
        clr     = 1'b0;
        clear_sb();
        step();
        test_reset();
        test_burst(0);
        test_burst(3);
        test_random_pulses();
        test_underflow();
        test_backpressure();
        test_short_and_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_axis_dac_sink
`default_nettype wire
